jtdsp16_rom_ctrl: RTL



---
 rtl/jtdsp16_rom_ctrl_if.sv | 25 ++
 rtl/jtdsp16_rom_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_rom_ctrl_if.sv
// Bus bundle for jtdsp16_rom_ctrl: the core fetch side (rom_*, flush) and the
// external burst memory side (ext_*). The controller uses the slave modport;
// whatever plays the core plus the memory uses the master modport.
interface jtdsp16_rom_ctrl_if;
  logic        rom_cs;
  logic [15:0] rom_addr;
  logic        flush;
  logic [15:0] rom_dout;
  logic        rom_ok;
  logic [15:0] ext_addr;
  logic        ext_req;
  logic        ext_ack;
  logic        ext_valid;
  logic [15:0] ext_data;

  modport master (
    output rom_cs, rom_addr, flush, ext_ack, ext_valid, ext_data,
    input  rom_dout, rom_ok, ext_addr, ext_req
  );

  modport slave (
    input  rom_cs, rom_addr, flush, ext_ack, ext_valid, ext_data,
    output rom_dout, rom_ok, ext_addr, ext_req
  );
endinterface

// File: rtl/jtdsp16_rom_ctrl.sv
// DSP16 program-memory responder: a single direct-tag line buffer of 2**LW
// words, refilled on a miss by a burst from an external 16-bit memory.
// Optional JTDSP16_ROM_PREFETCH_EN adds a next-line buffer filled by an
// automatic prefetch after each demand fill and swapped in when the core
// crosses into it.
module jtdsp16_rom_ctrl #(
  parameter int unsigned LW = 2
) (
  input logic              clk,
  input logic              rst,
  jtdsp16_rom_ctrl_if.slave bus
);

  localparam int unsigned LINE = 2 ** LW;
  localparam int unsigned TW   = 16 - LW;
  localparam logic [LW-1:0] LastIdx = LW'(LINE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill
`ifdef JTDSP16_ROM_PREFETCH_EN
    , StPreq,
    StPfill
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [15:0]   ext_addr_q, ext_addr_d;
  logic          flush_pend_q, flush_pend_d;
  logic [15:0]   line_q [LINE];
  logic [15:0]   line_d [LINE];

  logic [TW-1:0] addr_tag;
  logic [LW-1:0] addr_idx;
  logic          hit, nhit, beat, keep, nl_fill;

  assign addr_tag = bus.rom_addr[15:LW];
  assign addr_idx = bus.rom_addr[LW-1:0];
  assign hit      = valid_q && (tag_q == addr_tag);

`ifdef JTDSP16_ROM_PREFETCH_EN
  logic          nvalid_q, nvalid_d;
  logic [TW-1:0] ntag_q, ntag_d;
  logic [15:0]   nline_q [LINE];
  logic [15:0]   nline_d [LINE];

  assign nhit    = nvalid_q && (ntag_q == addr_tag);
  assign nl_fill = (state_q == StPreq) || (state_q == StPfill);
`else
  assign nhit    = 1'b0;
  assign nl_fill = 1'b0;
`endif

  // Core-facing data and handshake are combinational on the current address.
  always_comb begin
    bus.rom_ok   = bus.rom_cs && (hit || nhit);
    bus.rom_dout = '0;
    if (hit) begin
      bus.rom_dout = line_q[addr_idx];
`ifdef JTDSP16_ROM_PREFETCH_EN
    end else if (nhit) begin
      bus.rom_dout = nline_q[addr_idx];
`endif
    end
    bus.ext_addr = ext_addr_q;
`ifdef JTDSP16_ROM_PREFETCH_EN
    bus.ext_req  = (state_q == StReq) || (state_q == StPreq);
`else
    bus.ext_req  = (state_q == StReq);
`endif
  end

  // Next-state: miss launch, request handshake, burst capture and flush handling.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    ext_addr_d   = ext_addr_q;
    flush_pend_d = flush_pend_q;
    line_d       = line_q;
    beat         = 1'b0;
    keep         = 1'b0;
`ifdef JTDSP16_ROM_PREFETCH_EN
    nvalid_d     = nvalid_q;
    ntag_d       = ntag_q;
    nline_d      = nline_q;
`endif

    if (bus.flush) begin
      valid_d = 1'b0;
`ifdef JTDSP16_ROM_PREFETCH_EN
      nvalid_d = 1'b0;
`endif
    end

    unique case (state_q)
      StIdle: begin
        flush_pend_d = 1'b0;
        if (bus.rom_cs && !hit) begin
`ifdef JTDSP16_ROM_PREFETCH_EN
          if (nhit && !bus.flush) begin
            // Core moved into the next line: promote it and prefetch the one after.
            line_d     = nline_q;
            tag_d      = ntag_q;
            valid_d    = 1'b1;
            nvalid_d   = 1'b0;
            ntag_d     = ntag_q + 1'b1;
            ext_addr_d = {ntag_q + 1'b1, {LW{1'b0}}};
            state_d    = StPreq;
          end else
`endif
          begin
            ext_addr_d = {addr_tag, {LW{1'b0}}};
            tag_d      = addr_tag;
            valid_d    = 1'b0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.ext_ack) begin
          state_d = StFill;
          beat    = bus.ext_valid;
        end
      end
      StFill: begin
        if (bus.flush) flush_pend_d = 1'b1;
        beat = bus.ext_valid;
      end
`ifdef JTDSP16_ROM_PREFETCH_EN
      StPreq: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.ext_ack) begin
          state_d = StPfill;
          beat    = bus.ext_valid;
        end
      end
      StPfill: begin
        if (bus.flush) flush_pend_d = 1'b1;
        beat = bus.ext_valid;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (beat) begin
      cnt_d = cnt_q + 1'b1;
`ifdef JTDSP16_ROM_PREFETCH_EN
      if (nl_fill) nline_d[cnt_q] = bus.ext_data;
      else         line_d[cnt_q]  = bus.ext_data;
`else
      line_d[cnt_q] = bus.ext_data;
`endif
      if (cnt_q == LastIdx) begin
        // A flush seen at any point of the burst, including its last beat, wins.
        keep         = !(flush_pend_q || bus.flush);
        cnt_d        = '0;
        flush_pend_d = 1'b0;
        state_d      = StIdle;
`ifdef JTDSP16_ROM_PREFETCH_EN
        if (nl_fill) begin
          nvalid_d = keep;
        end else begin
          valid_d = keep;
          if (keep) begin
            ntag_d     = tag_q + 1'b1;
            nvalid_d   = 1'b0;
            ext_addr_d = {tag_q + 1'b1, {LW{1'b0}}};
            state_d    = StPreq;
          end
        end
`else
        valid_d = keep;
`endif
      end
    end
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      cnt_q        <= '0;
      ext_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < LINE; i++) line_q[i] <= '0;
`ifdef JTDSP16_ROM_PREFETCH_EN
      nvalid_q     <= 1'b0;
      ntag_q       <= '0;
      for (int i = 0; i < LINE; i++) nline_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      ext_addr_q   <= ext_addr_d;
      flush_pend_q <= flush_pend_d;
      line_q       <= line_d;
`ifdef JTDSP16_ROM_PREFETCH_EN
      nvalid_q     <= nvalid_d;
      ntag_q       <= ntag_d;
      nline_q      <= nline_d;
`endif
    end
  end

endmodule
